// File: rtl/sram_arbiter_2p.sv
// Two-requester round-robin arbiter and access sequencer for a 16x4 SRAM.
// Latency: grant one edge after req is sampled, done ACC_CYCLES edges after grant.
// Backpressure: requests are sampled only while idle; a requester holds its command until gnt.
module sram_arbiter_2p #(
   parameter int AW         = 4,
   parameter int DW         = 4,
   parameter int ACC_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          done0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [DW-1:0] mem_inp,
   output logic [AW-1:0] mem_addr,
   output logic          mem_cs,
   output logic          mem_we,
   input  logic [DW-1:0] mem_outp
);

   // Counter is at least one bit wide so ACC_CYCLES = 1 still elaborates.
   localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACC_CYCLES - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          prio_q, prio_d;     // requester that wins a tie
   logic          owner_q, owner_d;   // requester owning the current access
   logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic          done0_q, done0_d, done1_q, done1_d;
   logic          busy_q, busy_d;
   logic          cs_q, cs_d, we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] inp_q, inp_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          win;

   // Next-state and output logic: arbitrate in IDLE, count out the access window in ACCESS.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      busy_d  = busy_q;
      cs_d    = cs_q;
      we_d    = we_q;
      addr_d  = addr_q;
      inp_d   = inp_q;
      rdata_d = rdata_q;
      win     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               win     = (req0 && req1) ? prio_q : req1;
               owner_d = win;
               prio_d  = ~win;
               addr_d  = win ? addr1  : addr0;
               inp_d   = win ? wdata1 : wdata0;
               we_d    = win ? we1    : we0;
               cs_d    = 1'b1;
               busy_d  = 1'b1;
               gnt0_d  = ~win;
               gnt1_d  = win;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == LAST) begin
               // Capture read data on the last edge; a write leaves rdata untouched.
               if (!we_q) rdata_d = mem_outp;
               done0_d = ~owner_q;
               done1_d = owner_q;
               cs_d    = 1'b0;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         inp_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         inp_q   <= inp_d;
         rdata_q <= rdata_d;
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign busy     = busy_q;
   assign mem_cs   = cs_q;
   assign mem_we   = we_q;
   assign mem_addr = addr_q;
   assign mem_inp  = inp_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Self-checking bench: directed sequence with random data against an SRAM scoreboard.
// Two instances: ACC_CYCLES = 2 (main) and ACC_CYCLES = 1 (back-to-back throughput).
// Requesters are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_sram_arbiter_2p;
   localparam int ACC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT (ACC_CYCLES = 2) ----------------
   logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [3:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
   logic gnt0, done0, gnt1, done1, busy, mem_cs, mem_we;
   logic [3:0] rdata, mem_inp, mem_addr, mem_outp;
   logic [3:0] sram_a [16];
   logic [3:0] model [16];

   sram_arbiter_2p #(.AW(4), .DW(4), .ACC_CYCLES(ACC)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
      .rdata(rdata), .busy(busy), .mem_inp(mem_inp), .mem_addr(mem_addr),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_outp(mem_outp));

   always @(posedge clk) if (mem_cs && mem_we) sram_a[mem_addr] <= mem_inp;
   assign mem_outp = sram_a[mem_addr];

   // ---------------- second DUT (ACC_CYCLES = 1) ----------------
   logic b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
   logic [3:0] b_addr0 = 0, b_wdata0 = 0, b_addr1 = 0, b_wdata1 = 0;
   logic b_gnt0, b_done0, b_gnt1, b_done1, b_busy, b_mem_cs, b_mem_we;
   logic [3:0] b_rdata, b_mem_inp, b_mem_addr, b_mem_outp;
   logic [3:0] sram_b [16];
   logic [3:0] bmodel [16];

   sram_arbiter_2p #(.AW(4), .DW(4), .ACC_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .gnt0(b_gnt0), .done0(b_done0),
      .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .gnt1(b_gnt1), .done1(b_done1),
      .rdata(b_rdata), .busy(b_busy), .mem_inp(b_mem_inp), .mem_addr(b_mem_addr),
      .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_outp(b_mem_outp));

   always @(posedge clk) if (b_mem_cs && b_mem_we) sram_b[b_mem_addr] <= b_mem_inp;
   assign b_mem_outp = sram_b[b_mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus-level invariants: we only with cs, command stable across cs, never two grants.
   logic       pa_cs = 0, pb_cs = 0;
   logic [8:0] pa_cmd = 0, pb_cmd = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("we_without_cs", mem_we & ~mem_cs, 0);
         chk("b_we_without_cs", b_mem_we & ~b_mem_cs, 0);
         chk("gnt_overlap", gnt0 & gnt1, 0);
         if (pa_cs && mem_cs) chk("cmd_stable", {mem_we, mem_addr, mem_inp}, pa_cmd);
         if (pb_cs && b_mem_cs) chk("b_cmd_stable", {b_mem_we, b_mem_addr, b_mem_inp}, pb_cmd);
      end
      pa_cs = mem_cs; pa_cmd = {mem_we, mem_addr, mem_inp};
      pb_cs = b_mem_cs; pb_cmd = {b_mem_we, b_mem_addr, b_mem_inp};
   end

   // Most recently granted requester in the reference model (1 => requester 0 wins a tie).
   bit last_gnt = 1'b1;

   // One complete access on the main DUT from a single requester.
   task automatic acc2(input bit r, input bit w, input logic [3:0] a, input logic [3:0] d);
      int cs_cyc;
      bit got;
      logic [3:0] rd_before;
      @(negedge clk);
      req0 = !r; req1 = r; we0 = w; we1 = w; addr0 = a; addr1 = a; wdata0 = d; wdata1 = d;
      rd_before = rdata;
      @(posedge clk); #1;
      chk("gnt", {gnt1, gnt0}, r ? 2'b10 : 2'b01);
      chk("cs_on_grant", {mem_cs, busy, mem_we}, {2'b11, w});
      chk("mem_addr", mem_addr, a);
      if (w) chk("mem_inp", mem_inp, d);
      last_gnt = r;
      @(negedge clk);
      req0 = 0; req1 = 0;
      cs_cyc = 1; got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         if (done0 || done1) got = 1;
         else begin
            cs_cyc++;
            chk("hold", {gnt1, gnt0, mem_cs, busy}, 4'b0011);
         end
      end
      chk("done_timeout", got, 1);
      chk("cs_cycles", cs_cyc, ACC);
      chk("done_who", {done1, done0}, r ? 2'b10 : 2'b01);
      chk("end_idle", {mem_cs, mem_we, busy}, 0);
      if (w) begin
         chk("rdata_hold", rdata, rd_before);
         model[a] = d;
      end else begin
         chk("rdata", rdata, model[a]);
      end
      @(posedge clk); #1;
      chk("done_pulse", {done1, done0, gnt1, gnt0}, 0);
   endtask

   bit         got, exp_w;
   int         prev_g;
   bit         ow [8];
   logic [3:0] oa [8];
   logic [3:0] od [8];

   initial begin
      // 1. Reset, then idle with no requests.
      repeat (2) @(posedge clk);
      #1 chk("in_reset", {gnt0, gnt1, done0, done1, busy, mem_cs, mem_we, rdata, mem_addr, mem_inp}, 0);
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("idle_outputs", {gnt0, gnt1, done0, done1, busy, mem_cs, mem_we, rdata, mem_addr, mem_inp}, 0);
         chk("b_idle_outputs", {b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_mem_cs, b_mem_we,
                                b_rdata, b_mem_addr, b_mem_inp}, 0);
      end

      // 2. Requester 0 writes then reads address 3.
      acc2(0, 1, 4'd3, 4'hA);
      acc2(0, 0, 4'd3, 4'h0);
      chk("readback_A", rdata, 4'hA);

      // 3. Requester 0 fills memory, requester 1 reads it all back.
      for (int i = 0; i < 16; i++) acc2(0, 1, 4'(i), 4'($urandom_range(15)));
      for (int i = 0; i < 16; i++) acc2(1, 0, 4'(i), 4'h0);

      // 4. Both requesters held high: grants must alternate starting with requester 0.
      @(negedge clk);
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 4'd1; addr1 = 4'd2;
      for (int t = 0; t < 6; t++) begin
         exp_w = !last_gnt;
         got = 0;
         for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (gnt0 || gnt1) got = 1;
         end
         chk("rr_gnt_timeout", got, 1);
         chk("rr_gnt", {gnt1, gnt0}, exp_w ? 2'b10 : 2'b01);
         chk("rr_busy", busy, 1);
         last_gnt = exp_w;
         got = 0;
         for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (done0 || done1) got = 1;
         end
         chk("rr_done_timeout", got, 1);
         chk("rr_done", {done1, done0}, exp_w ? 2'b10 : 2'b01);
         chk("rr_rdata", rdata, model[exp_w ? 2 : 1]);
      end
      @(negedge clk);
      req0 = 0; req1 = 0;
      repeat (2) @(posedge clk);

      // 5. Reset during the first access cycle of a write to address 5.
      @(negedge clk);
      req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 4'hF;
      @(posedge clk); #1;
      chk("rst_gnt", gnt0, 1);
      #2 rst_n = 0;
      #1 chk("rst_abort", {mem_cs, mem_we, busy, gnt0, gnt1}, 0);
      @(negedge clk);
      req0 = 0; we0 = 0;
      @(negedge clk) rst_n = 1;
      last_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("rst_no_done", {done0, done1, mem_cs}, 0);
      end
      @(negedge clk);
      req0 = 1; req1 = 1; addr0 = 4'd1; addr1 = 4'd2;
      @(posedge clk); #1;
      chk("post_rst_gnt", {gnt1, gnt0}, 2'b01);
      @(negedge clk);
      req0 = 0; req1 = 0;
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         if (done0 || done1) got = 1;
      end
      chk("post_rst_done_timeout", got, 1);
      chk("post_rst_done", {done1, done0}, 2'b01);
      chk("post_rst_rdata", rdata, model[1]);

      // 6. ACC_CYCLES = 1: requester 1 streams writes then reads, one access per 2 cycles.
      for (int i = 0; i < 8; i++) begin
         ow[i] = (i < 4);
         oa[i] = 4'(((i % 4) * 3) + 1);
         od[i] = 4'($urandom_range(15));
      end
      @(negedge clk);
      b_req1 = 1; b_we1 = ow[0]; b_addr1 = oa[0]; b_wdata1 = od[0];
      prev_g = 0;
      for (int i = 0; i < 8; i++) begin
         got = 0;
         for (int k = 0; k < 6 && !got; k++) begin
            @(posedge clk); #1;
            if (b_gnt0 || b_gnt1) got = 1;
         end
         chk("b_gnt_timeout", got, 1);
         chk("b_gnt", {b_gnt1, b_gnt0}, 2'b10);
         if (i > 0) chk("b_spacing", cyc - prev_g, 2);
         prev_g = cyc;
         chk("b_cs", {b_mem_cs, b_mem_we, b_mem_addr}, {1'b1, ow[i], oa[i]});
         @(negedge clk);
         if (i < 7) begin
            b_we1 = ow[i+1]; b_addr1 = oa[i+1]; b_wdata1 = od[i+1];
         end else begin
            b_req1 = 0;
         end
         @(posedge clk); #1;
         chk("b_done", {b_done1, b_done0, b_mem_cs, b_busy}, 4'b1000);
         if (ow[i]) bmodel[oa[i]] = od[i];
         else chk("b_rdata", b_rdata, bmodel[oa[i]]);
      end
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sram_arbiter_2p.md
Name: sram_arbiter_2p

Overview:
- Two-requester, round-robin arbiter and access sequencer for the 16x4 cascaded SRAM (inp/addr/cs/we/outp).
- Accepts one read or write command per requester, holds SRAM address/data/we stable for a fixed access window, then returns read data and a per-requester done pulse.
- Sits between the SRAM and two client blocks, so neither client drives the SRAM directly.

Parameters:
- AW, 4, address width (16 words).
- DW, 4, data width.
- ACC_CYCLES, 2, cycles mem_cs is held per access. Minimum legal value is 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 command request.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- gnt0  out  1  one-cycle pulse: requester 0 command accepted.
- done0  out  1  one-cycle pulse: requester 0 access complete.
- req1, we1, addr1, wdata1, gnt1, done1: same as above, for requester 1.
- rdata  out  DW  read data, shared by both requesters; valid when done0 or done1 is high for a read.
- busy  out  1  high while an access is in progress.
- mem_inp  out  DW  to SRAM inp.
- mem_addr  out  AW  to SRAM addr.
- mem_cs  out  1  to SRAM cs.
- mem_we  out  1  to SRAM we.
- mem_outp  in  DW  from SRAM outp.

Behaviour:
- All outputs are registered.
- Reset values (asynchronous, applied immediately on rst_n low):
  - gnt0, gnt1, done0, done1, busy, mem_cs, mem_we = 0.
  - rdata, mem_addr, mem_inp = 0.
  - Round-robin pointer set so that requester 0 has priority.
  - State = IDLE.
- States: IDLE, ACCESS.
- IDLE:
  - req0/req1 are sampled only in this state.
  - If any req is high at a rising edge:
    - Select winner (rule below).
    - Latch winner's addr/wdata/we into mem_addr/mem_inp/mem_we.
    - Set mem_cs = 1, busy = 1, gnt_winner = 1, counter = 0.
    - Move to ACCESS.
  - No req: remain in IDLE, all pulses 0.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not granted most recently wins.
  - Pointer updates on every grant.
  - First simultaneous request after reset goes to requester 0.
- ACCESS:
  - gnt pulse clears after one cycle.
  - mem_addr, mem_inp, mem_we, mem_cs are held constant for exactly ACC_CYCLES cycles.
  - Counter increments each cycle.
  - At the edge where counter == ACC_CYCLES-1:
    - rdata <= mem_outp if the access is a read; rdata holds its previous value on a write.
    - done_winner = 1 for one cycle.
    - mem_cs = 0, mem_we = 0, busy = 0.
    - Return to IDLE.
  - Requests arriving during ACCESS are ignored until IDLE.
- Timing:
  - Latency from req sampled to done pulse: ACC_CYCLES+1 edges.
  - Throughput: one access per ACC_CYCLES+1 cycles. Back-to-back grants are allowed in the IDLE cycle that carries done.
- Requester protocol:
  - Hold req, we, addr, wdata stable until gnt is seen.
  - Deassert req on the edge after gnt. A req still high in the next IDLE is treated as a new command.
  - Command inputs are don't-care after gnt.
- mem_we is never high while mem_cs is low. mem_addr and mem_inp never change while mem_cs is high.
- Reset mid-ACCESS: the access is aborted, mem_cs/mem_we drop immediately, and no done is issued. A partial write leaves SRAM content undefined at that address.
- mem_outp is ignored outside the capture edge.

Test Plan:
1. Reset with rst_n = 0, then release; no req for 5 cycles -> all outputs 0, busy 0, state stays IDLE.
2. Requester 0 alone writes addr = 3, wdata = 4'hA, then reads addr = 3 -> gnt0 one cycle after req sampled; mem_cs high exactly 2 cycles per access; done0 on the third edge; read returns rdata = 4'hA.
3. Requester 0 writes all 16 addresses with $random data, then requester 1 reads all 16 -> every rdata matches the scoreboard; done1 only, never done0, during the reads.
4. req0 and req1 asserted together, each held (re-requesting after gnt) for 6 transactions -> grants alternate 0,1,0,1,0,1 starting with 0; no gnt overlap; busy never high in two overlapping accesses.
5. rst_n pulsed low in the first ACCESS cycle of a write to addr = 5 -> mem_cs/mem_we go 0 asynchronously; no done; next simultaneous request is granted to requester 0.
6. ACC_CYCLES = 1 build, back-to-back requests from requester 1 -> one access every 2 cycles; mem_cs high for 1 cycle each; data correct.
